// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------------------------
// wb_pkg: definitions shared by the Wishbone command master and its timeout counter.
//   state_t     transfer FSM states (idle, bus cycle in flight, response waiting)
//   WB_AW/WB_DW default address / data widths
//   WB_ERR_DAT  response data returned with a timeout error
// ---------------------------------------------------------------------------------------------
package wb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_t;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  localparam logic [WB_DW-1:0] WB_ERR_DAT = '0;

endpackage

// File: rtl/wb_timeout_ctr.sv
// ---------------------------------------------------------------------------------------------
// wb_timeout_ctr: counts cycles spent waiting for a Wishbone ACK.
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_clr      synchronous clear (takes priority over i_en)
//   i_en       count this cycle
//   o_expire   high while enabled on the last allowed cycle (count == TIMEOUT_CYC-1)
// ---------------------------------------------------------------------------------------------
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      // Wraps only on the expiry cycle, after which the owner has already left the bus state.
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------------------------
// wb_cmd_master: Wishbone classic single-transfer master.
// Takes one command at a time from a valid/ready port, runs one Wishbone cycle, and returns
// read data (or a timeout error) on a valid/ready response port. All outputs are registered.
//   wb_clk_i / wb_rst_ni           clock / asynchronous active-low reset
//   en_i                           enables command acceptance only
//   cmd_valid_i / cmd_ready_o      command handshake; cmd_we/adr/dat/sel_i command fields
//   wbm_cyc/stb/we/sel/adr/dat_o   Wishbone master outputs
//   wbm_ack_i / wbm_dat_i          Wishbone slave ACK and read data
//   rsp_valid_o / rsp_ready_i      response handshake; rsp_dat_o data, rsp_err_o timeout flag
// ---------------------------------------------------------------------------------------------
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int unsigned AW          = WB_AW,
  parameter int unsigned DW          = WB_DW,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            en_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o
);

  state_t          r_state;
  logic            r_cmd_ready;
  logic            r_cyc;
  logic            r_stb;
  logic            r_we;
  logic [DW/8-1:0] r_sel;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_wdat;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_dat;
  logic            r_rsp_err;

  logic w_accept;
  logic w_in_bus;
  logic w_expire;

  assign w_accept = (r_state == StIdle) && cmd_valid_i && r_cmd_ready;
  assign w_in_bus = (r_state == StBus);

  wb_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_ni),
    .i_clr    (w_accept),
    .i_en     (w_in_bus),
    .o_expire (w_expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_wdat      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state     <= StBus;
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_we        <= cmd_we_i;
            r_sel       <= cmd_sel_i;
            r_adr       <= cmd_adr_i;
            r_wdat      <= cmd_we_i ? cmd_dat_i : '0;
          end else begin
            r_cmd_ready <= en_i;
          end
        end
        StBus: begin
          // ACK is checked first so an ACK on the expiry cycle completes normally.
          if (wbm_ack_i) begin
            r_state     <= StResp;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
            r_rsp_err   <= 1'b0;
          end else if (w_expire) begin
            r_state     <= StResp;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= WB_ERR_DAT[DW-1:0];
            r_rsp_err   <= 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_cmd_ready <= en_i;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_cmd_ready <= 1'b0;
          r_cyc       <= 1'b0;
          r_stb       <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_stb;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_wdat;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------------------------
// tb_wb_cmd_master: self-checking bench for wb_cmd_master with a transaction-level reference
// model, a per-cycle compare process, directed scenarios and randomized traffic.
// ---------------------------------------------------------------------------------------------
module tb_wb_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .AW(32), .DW(32), .TIMEOUT_CYC(TO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .en_i        (en_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the master is either waiting for a command, holding one transfer on the
  // bus (for at most TO STB cycles), or holding one response until it is taken.
  logic        m_ready, m_bus, m_rsp, m_we, m_err;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_wdat, m_rdat;
  int          m_elapsed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b0; m_bus <= 1'b0; m_rsp <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
      m_sel <= '0; m_adr <= '0; m_wdat <= '0; m_rdat <= '0; m_elapsed <= 0;
    end else if (m_bus) begin
      if (wbm_ack_i) begin
        m_bus <= 1'b0; m_rsp <= 1'b1; m_err <= 1'b0;
        m_rdat <= m_we ? 32'h0 : wbm_dat_i;
      end else if (m_elapsed + 1 == TO) begin
        m_bus <= 1'b0; m_rsp <= 1'b1; m_err <= 1'b1; m_rdat <= 32'h0;
      end else begin
        m_elapsed <= m_elapsed + 1;
      end
    end else if (m_rsp) begin
      if (rsp_ready_i) begin
        m_rsp <= 1'b0; m_ready <= en_i;
      end
    end else if (cmd_valid_i && m_ready) begin
      m_bus <= 1'b1; m_ready <= 1'b0; m_elapsed <= 0;
      m_we <= cmd_we_i; m_sel <= cmd_sel_i; m_adr <= cmd_adr_i;
      m_wdat <= cmd_we_i ? cmd_dat_i : 32'h0;
    end else begin
      m_ready <= en_i;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd_ready", cmd_ready_o, m_ready);
      chk("cyc", wbm_cyc_o, m_bus);
      chk("stb", wbm_stb_o, m_bus);
      if (m_bus) begin
        chk("we", wbm_we_o, m_we);
        chk("sel", wbm_sel_o, m_sel);
        chk("adr", wbm_adr_o, m_adr);
        chk("wdat", wbm_dat_o, m_wdat);
      end
      chk("rsp_valid", rsp_valid_o, m_rsp);
      if (m_rsp) begin
        chk("rsp_dat", rsp_dat_o, m_rdat);
        chk("rsp_err", rsp_err_o, m_err);
      end
    end
  end

  // Present a command until accepted (bounded).
  task automatic accept_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
    bit done = 0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    cmd_valid_i = 1'b0;
    if (!done) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  // Act as the slave: ACK on STB cycle ack_after+1 (never if negative).
  task automatic bus_phase(input int ack_after, input logic [31:0] rdat, output int stb_len,
                           output logic cap_we, output logic [31:0] cap_adr,
                           output logic [31:0] cap_dat, output logic [3:0] cap_sel);
    bit done = 0;
    stb_len = 0;
    wbm_dat_i = rdat;
    for (int i = 0; i < TO + 6 && !done; i++) begin
      @(negedge clk);
      if (!wbm_stb_o) begin
        done = 1;
      end else begin
        stb_len++;
        if (stb_len == 1) begin
          cap_we = wbm_we_o; cap_adr = wbm_adr_o; cap_dat = wbm_dat_o; cap_sel = wbm_sel_o;
        end
        wbm_ack_i = (stb_len - 1 == ack_after);
      end
    end
    wbm_ack_i = 1'b0;
    if (!done) chk("stb_stuck", 1'b1, 1'b0);
  endtask

  // Called at the negedge right after STB fell: hold off ready, then consume.
  task automatic rsp_phase(input int delay, output logic [31:0] dat, output logic err);
    dat = rsp_dat_o;
    err = rsp_err_o;
    chk("rsp_present", rsp_valid_o, 1'b1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid_o, 1'b1);
      chk("hold_ready", cmd_ready_o, 1'b0);
      chk("hold_dat", rsp_dat_o, dat);
      chk("hold_err", rsp_err_o, err);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
  endtask

  int          l_len;
  logic        l_we, l_err;
  logic [31:0] l_adr, l_wd, l_rd;
  logic [3:0]  l_sel;

  initial begin : main
    // Reset values
    #22;
    chk("rst_cmd_ready", cmd_ready_o, 1'b0);
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_we", wbm_we_o, 1'b0);
    chk("rst_sel", wbm_sel_o, 4'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_wdat", wbm_dat_o, 32'h0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_dat", rsp_dat_o, 32'h0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    rst_n = 1'b1;

    // Read, ACK two cycles after STB rises
    accept_cmd(1'b0, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    bus_phase(2, 32'hCAFE_F00D, l_len, l_we, l_adr, l_wd, l_sel);
    rsp_phase(0, l_rd, l_err);
    chk("rd_stb_len", l_len, 3);
    chk("rd_we", l_we, 1'b0);
    chk("rd_wdat_zero", l_wd, 32'h0);
    chk("rd_dat", l_rd, 32'hCAFE_F00D);
    chk("rd_err", l_err, 1'b0);

    // Write, immediate ACK
    accept_cmd(1'b1, 32'h3000_0004, 32'h1234_5678, 4'b0011);
    bus_phase(0, 32'h5555_AAAA, l_len, l_we, l_adr, l_wd, l_sel);
    rsp_phase(0, l_rd, l_err);
    chk("wr_stb_len", l_len, 1);
    chk("wr_we", l_we, 1'b1);
    chk("wr_adr", l_adr, 32'h3000_0004);
    chk("wr_dat", l_wd, 32'h1234_5678);
    chk("wr_sel", l_sel, 4'b0011);
    chk("wr_rsp_dat", l_rd, 32'h0);
    chk("wr_err", l_err, 1'b0);

    // No ACK: timeout after exactly TO STB cycles
    accept_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    bus_phase(-1, 32'hFFFF_FFFF, l_len, l_we, l_adr, l_wd, l_sel);
    rsp_phase(0, l_rd, l_err);
    chk("to_stb_len", l_len, 16);
    chk("to_err", l_err, 1'b1);
    chk("to_dat", l_rd, 32'h0);

    // ACK on the last allowed cycle wins over the timeout
    accept_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    bus_phase(15, 32'h0BAD_CAFE, l_len, l_we, l_adr, l_wd, l_sel);
    rsp_phase(0, l_rd, l_err);
    chk("late_stb_len", l_len, 16);
    chk("late_err", l_err, 1'b0);
    chk("late_dat", l_rd, 32'h0BAD_CAFE);

    // Stray ACK while idle
    @(negedge clk);
    wbm_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stray_rsp", rsp_valid_o, 1'b0);
      chk("stray_cyc", wbm_cyc_o, 1'b0);
    end
    wbm_ack_i = 1'b0;

    // Response held off for 5 cycles
    accept_cmd(1'b0, 32'h3000_0030, 32'h0, 4'h1);
    bus_phase(1, 32'h7777_0001, l_len, l_we, l_adr, l_wd, l_sel);
    rsp_phase(5, l_rd, l_err);
    chk("hold_final_dat", l_rd, 32'h7777_0001);

    // Disabled master accepts nothing
    @(negedge clk);
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("dis_cyc", wbm_cyc_o, 1'b0);
      chk("dis_ready", cmd_ready_o, 1'b0);
    end
    cmd_valid_i = 1'b0;
    en_i = 1'b1;

    // Asynchronous reset in the middle of a bus cycle
    accept_cmd(1'b1, 32'h3000_0040, 32'hAAAA_5555, 4'hF);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", wbm_cyc_o, 1'b0);
    chk("arst_stb", wbm_stb_o, 1'b0);
    chk("arst_rsp_valid", rsp_valid_o, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    accept_cmd(1'b0, 32'h3000_0044, 32'h0, 4'hF);
    bus_phase(1, 32'h1357_9BDF, l_len, l_we, l_adr, l_wd, l_sel);
    rsp_phase(0, l_rd, l_err);
    chk("post_rst_len", l_len, 2);
    chk("post_rst_dat", l_rd, 32'h1357_9BDF);
    chk("post_rst_err", l_err, 1'b0);

    // Randomized traffic with varying ACK density (0% forces timeouts)
    for (int seg = 0; seg < 4; seg++) begin
      int pct;
      pct = (seg == 0) ? 50 : (seg == 1) ? 25 : (seg == 2) ? 6 : 0;
      for (int c = 0; c < 600; c++) begin
        @(posedge clk); #1;
        en_i        = ($urandom_range(0, 7) != 0);
        cmd_valid_i = $urandom_range(0, 1) == 1;
        cmd_we_i    = $urandom_range(0, 1) == 1;
        cmd_adr_i   = $urandom;
        cmd_dat_i   = $urandom;
        cmd_sel_i   = 4'($urandom_range(0, 15));
        wbm_ack_i   = ($urandom_range(0, 99) < pct);
        wbm_dat_i   = $urandom;
        rsp_ready_i = $urandom_range(0, 1) == 1;
      end
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0; wbm_ack_i = 1'b0; rsp_ready_i = 1'b0; en_i = 1'b1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
